// File: rtl/apb_slave_responder.sv
// APB4 completer backed by a resettable word memory, with programmable wait states,
// an error response on illegal addresses, and a sticky protocol-violation flag.
module apb_slave_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [3:0]            pstrb,
    input  logic [3:0]            wait_cfg,
    output logic                  pready,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pslverr,
    output logic                  proto_err
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                  state_reg;
    logic [3:0]              cnt_reg;
    logic                    pwrite_reg;
    logic [ADDR_WIDTH-1:0]   paddr_reg;
    logic [DATA_WIDTH-1:0]   pwdata_reg;
    logic [3:0]              pstrb_reg;
    logic                    pready_reg;
    logic [DATA_WIDTH-1:0]   prdata_reg;
    logic                    pslverr_reg;
    logic                    proto_err_reg;

    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    // In IDLE the response is computed from the live setup inputs, otherwise from the captured request.
    logic [ADDR_WIDTH-1:0]   dec_addr;
    logic                    dec_write;
    logic                    dec_legal;
    logic [IDX_W-1:0]        dec_idx;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rsp_err;

    assign dec_addr  = (state_reg == IDLE) ? paddr  : paddr_reg;
    assign dec_write = (state_reg == IDLE) ? pwrite : pwrite_reg;
    assign dec_legal = (dec_addr[1:0] == 2'b00) && ((dec_addr >> (IDX_W + 2)) == '0);
    assign dec_idx   = dec_addr[2 +: IDX_W];
    assign rd_data   = (dec_legal && !dec_write) ? mem[dec_idx] : '0;
    assign rsp_err   = !dec_legal;

    logic setup;
    logic idle_viol;
    logic req_changed;
    logic acc_viol;
    logic complete;
    logic commit;
    logic [IDX_W-1:0] commit_idx;

    assign setup       = (state_reg == IDLE) && psel && !penable;
    assign idle_viol   = (state_reg == IDLE) && psel && penable;
    assign req_changed = (paddr != paddr_reg) || (pwrite != pwrite_reg) ||
                         (pwdata != pwdata_reg) || (pstrb != pstrb_reg);
    assign acc_viol    = (state_reg == ACCESS) && (!psel || !penable || req_changed);
    assign complete    = (state_reg == ACCESS) && !acc_viol && pready_reg;
    assign commit      = complete && dec_write && dec_legal;
    assign commit_idx  = paddr_reg[2 +: IDX_W];

    generate
        for (genvar gi = 0; gi < MEM_DEPTH; gi++) begin : g_word
            always_ff @(posedge aclk or negedge aresetn) begin
                if (!aresetn) begin
                    mem[gi] <= '0;
                end else if (commit && (commit_idx == IDX_W'(gi))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (pstrb_reg[b]) begin
                            mem[gi][8*b +: 8] <= pwdata_reg[8*b +: 8];
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            pstrb_reg     <= '0;
            pready_reg    <= 1'b0;
            prdata_reg    <= '0;
            pslverr_reg   <= 1'b0;
            proto_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (setup) begin
                        pwrite_reg <= pwrite;
                        paddr_reg  <= paddr;
                        pwdata_reg <= pwdata;
                        pstrb_reg  <= pstrb;
                        cnt_reg    <= wait_cfg;
                        state_reg  <= ACCESS;
                        if (wait_cfg == 4'd0) begin
                            pready_reg  <= 1'b1;
                            prdata_reg  <= rd_data;
                            pslverr_reg <= rsp_err;
                        end
                    end else if (idle_viol) begin
                        proto_err_reg <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (acc_viol) begin
                        // Abandon the transfer: nothing is committed.
                        proto_err_reg <= 1'b1;
                        state_reg     <= IDLE;
                        cnt_reg       <= '0;
                        pready_reg    <= 1'b0;
                        prdata_reg    <= '0;
                        pslverr_reg   <= 1'b0;
                    end else if (pready_reg) begin
                        state_reg   <= IDLE;
                        cnt_reg     <= '0;
                        pready_reg  <= 1'b0;
                        prdata_reg  <= '0;
                        pslverr_reg <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                        if (cnt_reg == 4'd1) begin
                            pready_reg  <= 1'b1;
                            prdata_reg  <= rd_data;
                            pslverr_reg <= rsp_err;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign pready    = pready_reg;
    assign prdata    = prdata_reg;
    assign pslverr   = pslverr_reg;
    assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_apb_slave_responder.sv
// Bench for apb_slave_responder: directed scenarios plus random transfers against a word-array model.
module tb_apb_slave_responder;

    logic        aclk;
    logic        aresetn;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [3:0]  wait_cfg;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic        proto_err;

    apb_slave_responder #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .MEM_DEPTH (256)
    ) dut (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .wait_cfg (wait_cfg),
        .pready   (pready),
        .prdata   (prdata),
        .pslverr  (pslverr),
        .proto_err(proto_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain word array plus the sticky violation flag.
    logic [31:0] ref_mem [256];
    logic        ref_proto;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit addr_legal(input logic [31:0] a);
        return (a % 4 == 0) && (a < 32'd1024);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        ref_proto = 1'b0;
    endtask

    task automatic go_idle();
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the completion edge with psel still high,
    // so the caller may start another setup immediately or go idle.
    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [3:0] wcfg);
        int          n;
        logic [31:0] got_data;
        logic        got_err;
        bit          legal;
        logic [31:0] exp_data;
        legal    = addr_legal(addr);
        exp_data = (legal && !wr) ? ref_mem[addr / 4] : 32'd0;
        psel     = 1'b1;
        penable  = 1'b0;
        pwrite   = wr;
        paddr    = addr;
        pwdata   = data;
        pstrb    = strb;
        wait_cfg = wcfg;
        @(posedge aclk);
        @(negedge aclk);
        penable = 1'b1;
        n = 1;
        while (pready !== 1'b1 && n < 40) begin
            check("wait_rsp_zero", {prdata[30:0], pslverr}, 32'd0);
            @(posedge aclk);
            @(negedge aclk);
            n++;
        end
        check("pready", {31'd0, pready}, 32'd1);
        check("access_cycles", n, wcfg + 1);
        got_data = prdata;
        got_err  = pslverr;
        check("pslverr", {31'd0, got_err}, {31'd0, !legal});
        if (!wr) check("prdata", got_data, exp_data);
        @(posedge aclk);
        @(negedge aclk);
        if (wr && legal) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[addr / 4][8*b +: 8] = data[8*b +: 8];
        end
        check("pready_drop", {31'd0, pready}, 32'd0);
        check("proto_err", {31'd0, proto_err}, {31'd0, ref_proto});
        $display("txn %s addr=%h data=%h strb=%h wait=%0d err=%0b rdata=%h cycles=%0d",
                 wr ? "WR" : "RD", addr, data, strb, wcfg, got_err, got_data, n + 1);
    endtask

    task automatic do_reset_release();
        go_idle();
        @(negedge aclk);
        aresetn = 1'b1;
        model_clear();
        @(negedge aclk);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        bit          wr;
        aresetn  = 1'b0;
        psel     = 1'b0;
        penable  = 1'b0;
        pwrite   = 1'b0;
        paddr    = '0;
        pwdata   = '0;
        pstrb    = '0;
        wait_cfg = '0;
        model_clear();
        @(negedge aclk);
        @(negedge aclk);
        check("rst_pready", {31'd0, pready}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_pslverr", {31'd0, pslverr}, 32'd0);
        check("rst_proto", {31'd0, proto_err}, 32'd0);
        aresetn = 1'b1;
        @(negedge aclk);

        // Zero-wait write then read
        xfer(1, 32'h10, 32'hDEADBEEF, 4'hF, 4'd0);
        go_idle(); @(negedge aclk);
        xfer(0, 32'h10, 32'h0, 4'h0, 4'd0);
        go_idle(); @(negedge aclk);

        // Byte strobes with three wait states
        xfer(1, 32'h20, 32'h11223344, 4'hF, 4'd3);
        go_idle(); @(negedge aclk);
        xfer(1, 32'h20, 32'hAABBCCDD, 4'b0101, 4'd3);
        go_idle(); @(negedge aclk);
        xfer(0, 32'h20, 32'h0, 4'h0, 4'd3);
        check("strobe_merge", ref_mem[8], 32'h11BB33DD);
        go_idle(); @(negedge aclk);

        // Illegal addresses, then an untouched legal word
        xfer(0, 32'h400, 32'h0, 4'h0, 4'd0);
        xfer(1, 32'h06, 32'hCAFEF00D, 4'hF, 4'd0);
        xfer(0, 32'h04, 32'h0, 4'h0, 4'd0);
        xfer(1, 32'h24, 32'h12345678, 4'h0, 4'd1);
        xfer(0, 32'h24, 32'h0, 4'h0, 4'd0);
        go_idle(); @(negedge aclk);

        // Back-to-back
        xfer(1, 32'h30, 32'hA0A0A0A0, 4'hF, 4'd0);
        xfer(1, 32'h34, 32'hB1B1B1B1, 4'hF, 4'd0);
        xfer(1, 32'h38, 32'hC2C2C2C2, 4'hF, 4'd0);
        xfer(0, 32'h30, 32'h0, 4'h0, 4'd0);
        xfer(0, 32'h34, 32'h0, 4'h0, 4'd0);
        xfer(0, 32'h38, 32'h0, 4'h0, 4'd0);
        go_idle(); @(negedge aclk);

        // Violation: penable without setup
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h3C; pwdata = 32'h77777777; pstrb = 4'hF;
        @(posedge aclk);
        @(negedge aclk);
        ref_proto = 1'b1;
        check("viol_idle_proto", {31'd0, proto_err}, 32'd1);
        check("viol_idle_pready", {31'd0, pready}, 32'd0);
        go_idle(); @(negedge aclk);

        // Violation: address changes during the wait of a write
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h40; pwdata = 32'h55AA55AA;
        pstrb = 4'hF; wait_cfg = 4'd2;
        @(posedge aclk);
        @(negedge aclk);
        penable = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        paddr = 32'h44;
        @(posedge aclk);
        @(negedge aclk);
        check("viol_acc_proto", {31'd0, proto_err}, 32'd1);
        check("viol_acc_pready", {31'd0, pready}, 32'd0);
        go_idle(); @(negedge aclk);
        @(negedge aclk);
        check("viol_sticky", {31'd0, proto_err}, 32'd1);
        xfer(0, 32'h40, 32'h0, 4'h0, 4'd0);
        xfer(0, 32'h44, 32'h0, 4'h0, 4'd0);
        xfer(0, 32'h3C, 32'h0, 4'h0, 4'd0);
        go_idle(); @(negedge aclk);

        // Reset while pready is high on a read
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h10; pwdata = '0; pstrb = '0; wait_cfg = 4'd0;
        @(posedge aclk);
        @(negedge aclk);
        penable = 1'b1;
        check("pre_rst_pready", {31'd0, pready}, 32'd1);
        check("pre_rst_prdata", prdata, ref_mem[4]);
        #2 aresetn = 1'b0;
        #1;
        check("async_rst_pready", {31'd0, pready}, 32'd0);
        check("async_rst_prdata", prdata, 32'd0);
        check("async_rst_proto", {31'd0, proto_err}, 32'd0);
        do_reset_release();
        xfer(0, 32'h10, 32'h0, 4'h0, 4'd0);
        go_idle(); @(negedge aclk);

        // Reset during the wait state of a write
        xfer(1, 32'h50, 32'h0BADF00D, 4'hF, 4'd0);
        go_idle(); @(negedge aclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h50; pwdata = 32'h13572468;
        pstrb = 4'hF; wait_cfg = 4'd5;
        @(posedge aclk);
        @(negedge aclk);
        penable = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        check("wait_rst_pready", {31'd0, pready}, 32'd0);
        check("wait_rst_prdata", prdata, 32'd0);
        check("wait_rst_pslverr", {31'd0, pslverr}, 32'd0);
        do_reset_release();
        xfer(0, 32'h50, 32'h0, 4'h0, 4'd0);
        go_idle(); @(negedge aclk);

        // Random traffic
        for (int t = 0; t < 150; t++) begin
            wr = $urandom_range(0, 1);
            case ($urandom_range(0, 9))
                0:       a = 32'h400 + ($urandom_range(0, 63) * 4);
                1:       a = ($urandom_range(0, 15) * 4) + $urandom_range(1, 3);
                default: a = $urandom_range(0, 15) * 4;
            endcase
            d = $urandom;
            xfer(wr, a, d, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 0) begin
                go_idle();
                @(negedge aclk);
            end
        end
        go_idle(); @(negedge aclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
